// File: rtl/fpu_defs.sv
// rtl/fpu_defs.sv - shared binary32 constants, flag positions and normalized-beat type
package fpu_defs;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 24;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    localparam int FLG_OVF  = 3;
    localparam int FLG_UNF  = 2;
    localparam int FLG_INX  = 1;
    localparam int FLG_ZERO = 0;

    // Normalized beat handed from the shifter stage to the rounder.
    // exp is a 10-bit two's-complement value so underflow/overflow stay visible.
    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [23:0] mant;
        logic [2:0]  grs;
        logic        zero;
        logic        unf;
    } norm_t;

endpackage

// File: rtl/add_sub_round_rne.sv
// rtl/add_sub_round_rne.sv - round-to-nearest-even and binary32 packing with flags
import fpu_defs::*;

module add_sub_round_rne (
    input  norm_t       norm,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    logic               inc;
    logic [24:0]        sum;
    logic signed [9:0]  exp_r;
    logic [22:0]        frac;
    logic               hidden_unused;

    // Round, renormalize a carry out of the significand, then classify the beat.
    always_comb begin
        inc           = norm.grs[2] & (norm.grs[1] | norm.grs[0] | norm.mant[0]);
        sum           = {1'b0, norm.mant} + {24'h0, inc};
        hidden_unused = sum[23];
        exp_r         = norm.exp + (sum[24] ? 10'sd1 : 10'sd0);
        frac          = sum[24] ? 23'h0 : sum[22:0];
        result        = {norm.sign, exp_r[7:0], frac};
        flags         = 4'h0;
        flags[FLG_INX] = |norm.grs;

        if (norm.zero) begin
            result          = {norm.sign, 31'h0};
            flags           = 4'h0;
            flags[FLG_ZERO] = 1'b1;
        end else if (norm.unf) begin
            result         = {norm.sign, 31'h0};
            flags          = 4'h0;
            flags[FLG_UNF] = 1'b1;
            flags[FLG_INX] = 1'b1;
        end else if (exp_r >= 10'sd255) begin
            result         = {norm.sign, 8'hFF, 23'h0};
            flags          = 4'h0;
            flags[FLG_OVF] = 1'b1;
            flags[FLG_INX] = 1'b1;
        end
    end

endmodule

// File: rtl/add_sub_norm_round.sv
// rtl/add_sub_norm_round.sv - two-stage normalize/round post-adder stage with valid/ready
import fpu_defs::*;

module add_sub_norm_round #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic             in_carry,
    input  logic [MAN_W-1:0] in_mant,
    input  logic [2:0]       in_grs,
    input  logic [4:0]       in_shifts,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [3:0]       out_flags
);

    logic              s1_valid;
    logic              s2_valid;
    logic              adv1;
    logic              adv2;
    norm_t             n1;
    norm_t             s1;
    logic [26:0]       wide;
    logic signed [9:0] nexp;
    logic [31:0]       r_result;
    logic [3:0]        r_flags;

    assign adv2      = !s2_valid | out_ready;
    assign adv1      = !s1_valid | adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid;

    // Normalize: carry shifts right by one, otherwise shift left by the LZC count.
    always_comb begin
        n1      = '0;
        n1.sign = in_sign;
        wide    = {in_mant, in_grs} << in_shifts;
        nexp    = 10'sd0;
        if (in_carry) begin
            n1.mant = {1'b1, in_mant[23:1]};
            n1.grs  = {in_mant[0], in_grs[2], in_grs[1] | in_grs[0]};
            nexp    = {2'b00, in_exp} + 10'd1;
        end else if (in_shifts == 5'd24 && in_grs == 3'b000) begin
            n1.zero = 1'b1;
        end else begin
            n1.mant = wide[26:3];
            n1.grs  = wide[2:0];
            nexp    = {2'b00, in_exp} - {5'b00000, in_shifts};
        end
        n1.exp = nexp;
        n1.unf = !n1.zero && (nexp <= 10'sd0);
    end

    // Stage 1 register: captures the normalized beat when the pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1 <= n1;
            end
        end
    end

    add_sub_round_rne u_round (
        .norm   (s1),
        .result (r_result),
        .flags  (r_flags)
    );

    // Stage 2 register: holds the packed result steady while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            out_result <= 32'h0;
            out_flags  <= 4'h0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= r_result;
                out_flags  <= r_flags;
            end
        end
    end

endmodule

// File: tb/tb_add_sub_norm_round.sv
// tb/tb_add_sub_norm_round.sv - self-checking bench for add_sub_norm_round
module tb_add_sub_norm_round;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = 8'h0;
    logic        in_carry = 1'b0;
    logic [23:0] in_mant = 24'h0;
    logic [2:0]  in_grs = 3'h0;
    logic [4:0]  in_shifts = 5'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    int total = 0;
    int bad = 0;
    int outs = 0;
    bit rand_bp = 1'b0;
    logic [35:0] exp_q[$];

    add_sub_norm_round dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_carry   (in_carry),
        .in_mant    (in_mant),
        .in_grs     (in_grs),
        .in_shifts  (in_shifts),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // Reference: treat the significand as an integer and round by comparing the
    // discarded remainder with one half of the last kept unit.
    function automatic logic [35:0] model(input logic s, input logic [7:0] e, input logic c,
                                          input logic [23:0] m, input logic [2:0] g,
                                          input logic [4:0] sh);
        longint sig, mm, rem, half;
        int ex;
        bit up, inx;
        if (!c && sh == 5'd24 && g == 3'b000)
            return {4'b0001, s, 31'h0};
        if (c) begin
            sig  = (longint'(1) << 27) | (longint'(m) << 3) | longint'(g);
            ex   = int'(e) + 1;
            mm   = sig >> 4;
            rem  = sig & 15;
            half = 8;
        end else begin
            sig  = ((longint'(m) << 3) | longint'(g)) << sh;
            sig  = sig & ((longint'(1) << 27) - 1);
            ex   = int'(e) - int'(sh);
            mm   = sig >> 3;
            rem  = sig & 7;
            half = 4;
        end
        if (ex <= 0)
            return {4'b0110, s, 31'h0};
        inx = (rem != 0);
        up  = (rem > half) || (rem == half && mm[0]);
        mm  = mm + longint'(up);
        if (mm == (longint'(1) << 24)) begin
            mm = mm >> 1;
            ex = ex + 1;
        end
        if (ex >= 255)
            return {4'b1010, s, 8'hFF, 23'h0};
        return {2'b00, inx, 1'b0, s, ex[7:0], mm[22:0]};
    endfunction

    task automatic drive(input logic s, input logic [7:0] e, input logic c,
                         input logic [23:0] m, input logic [2:0] g, input logic [4:0] sh);
        in_sign = s; in_exp = e; in_carry = c; in_mant = m; in_grs = g; in_shifts = sh;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic s, input logic [7:0] e, input logic c,
                        input logic [23:0] m, input logic [2:0] g, input logic [4:0] sh,
                        input logic [31:0] er, input logic [3:0] ef);
        int n = 0;
        bit done = 1'b0;
        drive(s, e, c, m, g, sh);
        while (!done && n < 200) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({ef, er});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        total++;
        assert (done) else begin
            bad++;
            $error("FAIL send_timeout observed=%0d expected=1", done);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() > 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, 36'(exp_q.size()), 36'd0);
    endtask

    // Scoreboard: each handshaken output beat is compared with the oldest expectation.
    initial begin
        logic [35:0] want;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                outs++;
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", {out_flags, out_result}, 36'hF_FFFF_FFFF);
                end else begin
                    want = exp_q.pop_front();
                    chk($sformatf("out%0d", outs), {out_flags, out_result}, want);
                end
            end
        end
    end

    // Random downstream backpressure while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic        s, c;
        logic [7:0]  e;
        logic [23:0] m;
        logic [2:0]  g;
        logic [4:0]  sh;
        logic [35:0] r;

        #3;
        chk("reset_valid", 36'(out_valid), 36'd0);
        chk("reset_result", 36'(out_result), 36'd0);
        chk("reset_flags", 36'(out_flags), 36'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 36'(in_ready), 36'd1);

        send(1'b0, 8'd127, 1'b1, 24'h000000, 3'b000, 5'd0,  32'h4000_0000, 4'b0000);
        send(1'b0, 8'd130, 1'b0, 24'h000001, 3'b000, 5'd23, 32'h3580_0000, 4'b0000);
        send(1'b0, 8'd127, 1'b0, 24'hFFFFFF, 3'b100, 5'd0,  32'h4000_0000, 4'b0010);
        send(1'b0, 8'd254, 1'b1, 24'h123456, 3'b000, 5'd0,  32'h7F80_0000, 4'b1010);
        send(1'b1, 8'd5,   1'b0, 24'h002000, 3'b000, 5'd10, 32'h8000_0000, 4'b0110);
        send(1'b0, 8'd100, 1'b0, 24'h000000, 3'b000, 5'd24, 32'h0000_0000, 4'b0001);
        drain("directed_drain");

        out_ready = 1'b0;
        send(1'b0, 8'd127, 1'b1, 24'h000000, 3'b000, 5'd0, 32'h4000_0000, 4'b0000);
        send(1'b0, 8'd130, 1'b0, 24'h000001, 3'b000, 5'd23, 32'h3580_0000, 4'b0000);
        drive(1'b1, 8'd128, 1'b0, 24'h800000, 3'b000, 5'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", 36'(in_ready), 36'd0);
            chk("stall_out_valid", 36'(out_valid), 36'd1);
            chk("stall_hold", {out_flags, out_result}, {4'b0000, 32'h4000_0000});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(1'b1, 8'd128, 1'b0, 24'h800000, 3'b000, 5'd0, 32'hC000_0000, 4'b0000);
        drain("stall_drain");

        out_ready = 1'b0;
        send(1'b0, 8'd140, 1'b1, 24'h0F0F0F, 3'b011, 5'd0, 32'h0, 4'h0);
        send(1'b0, 8'd141, 1'b1, 24'h0F0F0F, 3'b011, 5'd0, 32'h0, 4'h0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 36'(out_valid), 36'd0);
        chk("rst_mid_result", {out_flags, out_result}, 36'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_ready", 36'(in_ready), 36'd1);
        chk("rst_release_valid", 36'(out_valid), 36'd0);

        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            c  = ($urandom_range(0, 3) == 0);
            s  = 1'($urandom);
            e  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 30)) : 8'($urandom_range(1, 254));
            if ($urandom_range(0, 7) == 0) e = 8'd254;
            m  = 24'($urandom);
            g  = 3'($urandom);
            sh = 5'($urandom_range(0, 24));
            if (!c) begin
                if (sh == 5'd24) begin
                    m = 24'h0;
                    g[1:0] = 2'b00;
                end else begin
                    m = (m >> sh) | (24'h800000 >> sh);
                    if (sh >= 5'd2) g[1:0] = 2'b00;
                end
                if (sh == 5'd0 && $urandom_range(0, 3) == 0) g = 3'b100;
            end
            r = model(s, e, c, m, g, sh);
            send(s, e, c, m, g, sh, r[31:0], r[35:32]);
        end
        drain("random_drain");
        rand_bp = 1'b0;
        out_ready = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/add_sub_norm_round.md
Name: add_sub_norm_round

Overview:
- Post-adder stage of the single-precision add/sub datapath.
- Consumes the raw adder mantissa, its guard/round/sticky bits, the carry-out and the leading-zero shift count from the leading-zero counter.
- Normalizes, rounds to nearest-even, handles exponent overflow and underflow, and emits a packed IEEE-754 binary32 result with flags.
- Two-stage valid/ready pipeline with backpressure, sitting between the LZC and the FPU result mux.

Parameters:
- EXP_W, 8, biased exponent width.
- MAN_W, 24, significand width including hidden bit. Fixed at binary32; the parameter exists only for documentation and checks.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_sign  in  1  result sign from the add/sub stage.
- in_exp  in  8  biased exponent of the larger operand.
- in_carry  in  1  adder carry-out.
- in_mant  in  24  adder result [24:1], same vector the LZC examines.
- in_grs  in  3  guard, round, sticky.
- in_shifts  in  5  LZC count, 0..24.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_result  out  32  {sign, exp[7:0], frac[22:0]}.
- out_flags  out  4  {overflow, underflow, inexact, zero}.

Behaviour:
- Reset, asynchronous on rst_n low:
  - Both stage valid bits clear.
  - out_valid=0, out_result=32'h0, out_flags=4'h0.
  - in_ready=1 one cycle after release.
  - Beats in flight are discarded; no partial output is ever produced.
- Handshake:
  - A beat transfers when valid and ready are both high on a rising edge.
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1, combinational from out_ready.
  - Latency is exactly 2 cycles with no stall; throughput is 1 beat per cycle.
  - Outputs stay stable while out_valid=1 and out_ready=0.
- Stage 1, normalize. Internal exponent is 10-bit signed.
  - in_carry=1: mantissa={1, in_mant[24:2]}; G'=in_mant[1]; R'=G; S'=R|S; exp=in_exp+1. in_shifts is ignored.
  - in_carry=0, in_shifts=24 and in_grs=0: exact zero. Set the zero flag, result {in_sign, 31'h0}.
  - Otherwise:
    - Shift the 27-bit {in_mant, G, R, S} left by in_shifts, filling zeros.
    - exp = in_exp - in_shifts.
    - Upstream guarantees R=S=0 whenever in_shifts>=2. The bench must honour this.
  - Underflow: normalized exp <= 0 flushes to {in_sign, 31'h0} with underflow=1 and inexact=1. There are no subnormals.
- Stage 2, round to nearest-even:
  - inc = G & (R | S | mant[0]).
  - mant+inc overflowing 24 bits gives mant=24'h800000 and exp+1.
  - inexact = G|R|S after normalization.
  - exp >= 255 after rounding gives {sign, 8'hFF, 23'h0} with overflow=1 and inexact=1.
  - A zero or underflow result bypasses rounding.
  - frac = mant[22:0]; the hidden bit is dropped.
- Flag exclusivity: at most one of zero, underflow or overflow is set per beat.

Decomposition:
- Shared package/include fpu_defs:
  - Constants EXP_BIAS=127, EXP_MAX=255, QNAN/INF encodings.
  - Flag bit positions FLG_OVF=3, FLG_UNF=2, FLG_INX=1, FLG_ZERO=0.
- One sub-module, add_sub_round_rne: combinational stage-2 rounding and overflow packing, reusable by the mul/div paths.
- The normalizing shifter stays inline.

Test Plan:
- 1.0+1.0: exp=127, carry=1, mant=24'h000000, grs=0 -> 2 cycles later 32'h40000000, flags 0.
- Cancellation: exp=130, mant=24'h000001, shifts=23, grs=0 -> 32'h35800000, flags 0.
- Round tie to even with carry-up: exp=127, mant=24'hFFFFFF, grs=3'b100 -> 32'h40000000, inexact=1.
- Overflow and underflow:
  - exp=254, carry=1 -> 32'h7F800000, overflow=1 and inexact=1.
  - exp=5, shifts=10 -> 32'h00000000, underflow=1.
- Zero: shifts=24, mant=0, grs=0, sign=0 -> 32'h00000000, zero=1.
- Backpressure and reset:
  - Hold out_ready=0 while offering 3 beats: 2 are accepted and in_ready drops.
  - Release out_ready: all 3 emerge in order, none lost.
  - Assert rst_n mid-stall: out_valid=0 immediately.
